// File: rtl/mcs_sync_pkg.sv
// Shared types and defaults for the AD9361 multi-chip-sync pulse sequencer.
package mcs_sync_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PPS = 3'd1,
    PULSE    = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int COUNT_W = 4;

  localparam int DEF_PULSE_WIDTH = 16;
  localparam int DEF_PULSE_GAP   = 64;
  localparam int DEF_NUM_PULSES  = 2;
  localparam int DEF_PPS_TIMEOUT = 200000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detect for an asynchronous strobe.
// rise_pulse is high for one cycle, three clk cycles after the raw edge.
module pps_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_reg;
  logic sync_reg;
  logic sync_d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      sync_d_reg <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      meta_reg   <= async_in;
      sync_reg   <= meta_reg;
      sync_d_reg <= sync_reg;
      rise_pulse <= sync_reg & ~sync_d_reg;
    end
  end

endmodule

// File: rtl/mcs_sync_seq.sv
// MCS pulse-train generator for the shared AD9361 mcs_sync pin.
// Define MCS_SYNC_SEQ_PPS_EN to build the optional PPS alignment and timeout.
module mcs_sync_seq
  import mcs_sync_pkg::*;
#(
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int PULSE_GAP   = DEF_PULSE_GAP,
  parameter int NUM_PULSES  = DEF_NUM_PULSES,
  parameter int PPS_TIMEOUT = DEF_PPS_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               use_pps,
  input  logic               pps,
  output logic               mcs_sync,
  output logic               busy,
  output logic               done,
  output logic               pps_timeout,
  output logic [COUNT_W-1:0] pulse_count
);

  // One phase counter serves both the high and the low portion of the train.
  localparam int PH_W = $clog2(max_int(PULSE_WIDTH, PULSE_GAP) + 1);

  state_t            state_reg;
  logic              req_q_reg;
  logic [PH_W-1:0]   phase_cnt_reg;
  logic              req_rise;
  logic [COUNT_W-1:0] count_inc;

  assign req_rise  = req & ~req_q_reg;
  assign count_inc = pulse_count + COUNT_W'(1);

`ifdef MCS_SYNC_SEQ_PPS_EN
  localparam int TO_W = $clog2(PPS_TIMEOUT + 1);

  logic [TO_W-1:0] timeout_cnt_reg;
  logic            pps_rise;

  pps_edge_sync u_pps_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (pps),
    .rise_pulse (pps_rise)
  );
`else
  logic unused_pps_inputs;
  assign unused_pps_inputs = &{1'b0, use_pps, pps};
  assign pps_timeout       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_q_reg     <= 1'b0;
      phase_cnt_reg <= '0;
      mcs_sync      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pulse_count   <= '0;
`ifdef MCS_SYNC_SEQ_PPS_EN
      timeout_cnt_reg <= '0;
      pps_timeout     <= 1'b0;
`endif
    end else begin
      req_q_reg <= req;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_rise) begin
            pulse_count <= '0;
            busy        <= 1'b1;
`ifdef MCS_SYNC_SEQ_PPS_EN
            pps_timeout <= 1'b0;
            if (use_pps) begin
              state_reg       <= WAIT_PPS;
              timeout_cnt_reg <= TO_W'(PPS_TIMEOUT - 1);
            end else begin
              state_reg     <= PULSE;
              mcs_sync      <= 1'b1;
              phase_cnt_reg <= PH_W'(PULSE_WIDTH - 1);
            end
`else
            state_reg     <= PULSE;
            mcs_sync      <= 1'b1;
            phase_cnt_reg <= PH_W'(PULSE_WIDTH - 1);
`endif
          end
        end
`ifdef MCS_SYNC_SEQ_PPS_EN
        // PPS beats an expiring timeout; a dropped req cancels silently.
        WAIT_PPS: begin
          if (pps_rise) begin
            state_reg     <= PULSE;
            mcs_sync      <= 1'b1;
            phase_cnt_reg <= PH_W'(PULSE_WIDTH - 1);
          end else if (timeout_cnt_reg == '0) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            pps_timeout <= 1'b1;
          end else if (!req) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg - TO_W'(1);
          end
        end
`endif
        PULSE: begin
          if (phase_cnt_reg == '0) begin
            pulse_count <= count_inc;
            mcs_sync    <= 1'b0;
            if (count_inc == COUNT_W'(NUM_PULSES)) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg     <= GAP;
              phase_cnt_reg <= PH_W'(PULSE_GAP - 1);
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg - PH_W'(1);
          end
        end
        GAP: begin
          if (phase_cnt_reg == '0) begin
            state_reg     <= PULSE;
            mcs_sync      <= 1'b1;
            phase_cnt_reg <= PH_W'(PULSE_WIDTH - 1);
          end else begin
            phase_cnt_reg <= phase_cnt_reg - PH_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          mcs_sync  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
